// File: rtl/gearbox_10to8_scheduler.sv
// gearbox_10to8_scheduler: issues 8 word slots per 10-clock frame to a 10b->8b gearbox, filling empty slots with FILL_WORD.
// Define GEARBOX_SCHED_STATS_EN to build the saturating underflow counter; otherwise underflow_cnt is tied to 0.
module gearbox_10to8_scheduler #(
    parameter logic [9:0] FILL_WORD = 10'h0FA,
    parameter int         CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             src_valid,
    input  logic [9:0]       src_data,
    output logic             src_ready,
    output logic             gb_valid,
    output logic [9:0]       gb_data,
    output logic             frame_start,
    output logic             busy,
    output logic             underflow,
    output logic [CNT_W-1:0] underflow_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
    state_t     state;
    logic [3:0] phase;
    logic       slot;
    assign slot      = (state != IDLE) && (phase < 4'd8);
    assign src_ready = slot;
    assign busy      = state != IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            phase       <= 4'd0;
            gb_valid    <= 1'b0;
            gb_data     <= 10'd0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            gb_valid    <= slot;
            underflow   <= slot && !src_valid;
            frame_start <= slot && (phase == 4'd0);
            if (slot)
                gb_data <= src_valid ? src_data : FILL_WORD;
            phase <= (state == IDLE || phase == 4'd9) ? 4'd0 : phase + 4'd1;
            // STOP keeps the frame running so the gearbox always sees whole frames
            case (state)
                IDLE:    if (enable) state <= RUN;
                RUN:     if (!enable) state <= (phase == 4'd9) ? IDLE : STOP;
                STOP:    if (phase == 4'd9) state <= IDLE; else if (enable) state <= RUN;
                default: state <= IDLE;
            endcase
        end
    end
`ifdef GEARBOX_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            underflow_cnt <= '0;
        else if (slot && !src_valid && underflow_cnt != '1)
            underflow_cnt <= underflow_cnt + CNT_W'(1);
    end
`else
    assign underflow_cnt = '0;
`endif
endmodule

// File: tb/tb_gearbox_10to8_scheduler.sv
// tb_gearbox_10to8_scheduler: randomized scoreboard bench; the model views the link as whole 10-cycle frames,
// chained back-to-back only when enable is high on a frame's last two cycles.
module tb_gearbox_10to8_scheduler;
    localparam int         CNT_W = 4;
    localparam logic [9:0] FILL  = 10'h0FA;

    logic             clk = 1'b0;
    logic             rst_n, enable, src_valid, src_ready;
    logic [9:0]       src_data, gb_data;
    logic             gb_valid, frame_start, busy, underflow;
    logic [CNT_W-1:0] underflow_cnt;

    gearbox_10to8_scheduler #(.FILL_WORD(FILL), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .src_valid(src_valid), .src_data(src_data),
        .src_ready(src_ready), .gb_valid(gb_valid), .gb_data(gb_data), .frame_start(frame_start),
        .busy(busy), .underflow(underflow), .underflow_cnt(underflow_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         v;
        logic [9:0] d;
        bit         uf;
        bit         fs;
        bit         bz;
        int         cnt;
    } exp_t;

    exp_t       q[$];
    int         checks = 0, errors = 0, vcount = 0;
    int         pos = -1;
    bit         en8 = 1'b0;
    logic [9:0] last = 10'd0;
    int         mcnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // pos is the position within the current frame of the upcoming cycle, -1 when the link is idle
    task automatic step(input bit en, input bit sv, input logic [9:0] sd);
        exp_t e;
        @(negedge clk);
        enable = en; src_valid = sv; src_data = sd;
        #1;
        chk("src_ready", int'(src_ready), int'(pos >= 0 && pos <= 7));
        if (pos >= 0 && pos <= 7) begin
            e.v = 1'b1; e.d = sv ? sd : FILL; e.uf = !sv; e.fs = (pos == 0);
            last = e.d;
`ifdef GEARBOX_SCHED_STATS_EN
            if (!sv && mcnt < (1 << CNT_W) - 1) mcnt++;
`endif
        end else begin
            e.v = 1'b0; e.d = last; e.uf = 1'b0; e.fs = 1'b0;
        end
        if (pos < 0) pos = en ? 0 : -1;
        else if (pos == 8) begin en8 = en; pos = 9; end
        else if (pos == 9) pos = (en8 && en) ? 0 : -1;
        else pos++;
        e.bz = pos >= 0;
        e.cnt = mcnt;
        q.push_back(e);
    endtask

    task automatic run_to(input int p);
        int g = 0;
        while (pos != p && g < 40) begin
            step(1'b1, 1'b1, 10'($urandom));
            g++;
        end
        chk("run_to_reached", pos, p);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gb_valid"}, int'(gb_valid), 0);
        chk({tag, "_gb_data"}, int'(gb_data), 0);
        chk({tag, "_frame_start"}, int'(frame_start), 0);
        chk({tag, "_underflow"}, int'(underflow), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_src_ready"}, int'(src_ready), 0);
        chk({tag, "_cnt"}, int'(underflow_cnt), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (gb_valid === 1'b1) vcount++;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("gb_valid", int'(gb_valid), int'(e.v));
                chk("gb_data", int'(gb_data), int'(e.d));
                chk("underflow", int'(underflow), int'(e.uf));
                chk("frame_start", int'(frame_start), int'(e.fs));
                chk("busy", int'(busy), int'(e.bz));
                chk("underflow_cnt", int'(underflow_cnt), e.cnt);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : driver
        bit en_r;
        rst_n = 1'b0; enable = 1'b0; src_valid = 1'b0; src_data = 10'd0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("por");
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 10'(i));
        run_to(0);
        for (int i = 0; i < 10; i++) step(1'b1, !(pos inside {3, 4, 5}), 10'($urandom));
        run_to(2);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 10'($urandom));
        chk("stop_idle_pos", pos, -1);
        chk("stop_valids_mod8", vcount % 8, 0);
        run_to(5);
        step(1'b0, 1'b1, 10'($urandom));
        step(1'b0, 1'b1, 10'($urandom));
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 10'($urandom));
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 10'($urandom));
        en_r = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0) en_r = ~en_r;
            step(en_r, $urandom_range(0, 3) != 0, 10'($urandom));
        end
        for (int i = 0; i < 25; i++) step(1'b0, 1'b1, 10'($urandom));
        chk("random_idle_pos", pos, -1);
        chk("random_valids_mod8", vcount % 8, 0);
        run_to(4);
        @(negedge clk);
        enable = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async");
        q.delete();
        pos = -1; last = 10'd0; mcnt = 0; vcount = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_src_ready", int'(src_ready), 0);
        chk("post_rst_busy", int'(busy), 0);
        for (int i = 0; i < 40; i++) step($urandom_range(0, 4) != 0, $urandom_range(0, 1) != 0, 10'($urandom));
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 10'($urandom));
        repeat (2) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
